prt_lb_mux_tmo: RTL and testbench



---
 rtl/prt_lb_mux_tmo.sv | 192 +++++++++++++++++++
 tb/tb_prt_lb_mux_tmo.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_lb_mux_tmo.sv
// prt_lb_mux_tmo
// Local-bus demultiplexer between the CPU data port and P_PORTS slaves.
// Decode, write strobes and read strobes are registered. A single read may
// be outstanding; a watchdog returns P_ERR_DAT if the slave never answers,
// so a hung or missing slave cannot stall the CPU.
//
// Ports
//   CLK_IN, RST_IN         clock, async active-low reset
//   LB_UP_*                upstream bus (word address, strobes, data, read valid)
//   LB_DWN_ADR/DIN_OUT     shared downstream address / write data
//   LB_DWN_WR/RD_OUT       per-port one-hot strobes
//   LB_DWN_DOUT/VLD_IN     per-port read data (port k at [k*P_DAT +: P_DAT]) / valid
//   STA_CLR_IN             clears sticky flags
//   STA_TMO/DEC/OVR_OUT    sticky: timeout, decode error, dropped request
//   STA_TMO_PORT_OUT       port of the most recent timeout
//   STA_BUSY_OUT           a read is outstanding
module prt_lb_mux_tmo #(
   parameter int               P_PORTS   = 9,
   parameter int               P_UP_ADR  = 22,
   parameter int               P_DWN_ADR = 16,
   parameter int               P_DAT     = 32,
   parameter int               P_TMO     = 256,
   parameter logic [P_DAT-1:0] P_ERR_DAT = P_DAT'(32'hDEAD_BEEF)
) (
   input  logic                       CLK_IN,
   input  logic                       RST_IN,
   input  logic [P_UP_ADR-1:0]        LB_UP_ADR_IN,
   input  logic                       LB_UP_WR_IN,
   input  logic                       LB_UP_RD_IN,
   input  logic [P_DAT-1:0]           LB_UP_DIN_IN,
   output logic [P_DAT-1:0]           LB_UP_DOUT_OUT,
   output logic                       LB_UP_VLD_OUT,
   output logic [P_DWN_ADR-1:0]       LB_DWN_ADR_OUT,
   output logic [P_DAT-1:0]           LB_DWN_DIN_OUT,
   output logic [P_PORTS-1:0]         LB_DWN_WR_OUT,
   output logic [P_PORTS-1:0]         LB_DWN_RD_OUT,
   input  logic [P_PORTS*P_DAT-1:0]   LB_DWN_DOUT_IN,
   input  logic [P_PORTS-1:0]         LB_DWN_VLD_IN,
   input  logic                       STA_CLR_IN,
   output logic                       STA_TMO_OUT,
   output logic [4:0]                 STA_TMO_PORT_OUT,
   output logic                       STA_DEC_OUT,
   output logic                       STA_OVR_OUT,
   output logic                       STA_BUSY_OUT
);

   localparam int SEL_W = (P_PORTS > 1) ? $clog2(P_PORTS) : 1;
   localparam int CNT_W = $clog2(P_TMO);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(P_TMO - 1);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [P_PORTS-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [P_DWN_ADR-1:0] adr_q, adr_d;
   logic [P_DAT-1:0]     din_q, din_d;
   logic                 vld_q, vld_d;
   logic [P_DAT-1:0]     dout_q, dout_d;
   logic                 tmo_q, tmo_d, dec_q, dec_d, ovr_q, ovr_d;
   logic [4:0]           tport_q, tport_d;

   logic [SEL_W-1:0]     sel;
   logic [P_PORTS-1:0]   sel_oh;
   logic                 sel_ok, idle, wr_go, rd_go, rd_bad, dec_ev, ovr_ev, tmo_ev;
   logic                 vld_sel;
   logic [P_DAT-1:0]     dat_sel;
   logic                 unused_adr;

   // Bits above the port select are don't-care.
   assign unused_adr = ^LB_UP_ADR_IN;

   always_comb begin
      sel     = LB_UP_ADR_IN[P_DWN_ADR +: SEL_W];
      vld_sel = 1'b0;
      dat_sel = '0;
      for (int k = 0; k < P_PORTS; k++) begin
         sel_oh[k] = (sel == SEL_W'(k));
         if (sel_q == SEL_W'(k)) begin
            vld_sel = LB_DWN_VLD_IN[k];
            dat_sel = LB_DWN_DOUT_IN[k*P_DAT +: P_DAT];
         end
      end
      sel_ok = |sel_oh;
      idle   = (state_q == IDLE);
      // A write always wins over a simultaneous read.
      wr_go  = idle & LB_UP_WR_IN & sel_ok;
      rd_go  = idle & LB_UP_RD_IN & ~LB_UP_WR_IN & sel_ok;
      rd_bad = idle & LB_UP_RD_IN & ~LB_UP_WR_IN & ~sel_ok;
      dec_ev = idle & (LB_UP_WR_IN | LB_UP_RD_IN) & ~sel_ok;
      ovr_ev = idle ? (LB_UP_WR_IN & LB_UP_RD_IN) : (LB_UP_WR_IN | LB_UP_RD_IN);
      tmo_ev = 1'b0;

      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      din_d   = din_q;
      wr_d    = wr_go ? sel_oh : '0;
      rd_d    = rd_go ? sel_oh : '0;
      vld_d   = 1'b0;
      dout_d  = dout_q;
      tport_d = tport_q;

      if (wr_go | rd_go) begin
         adr_d = LB_UP_ADR_IN[P_DWN_ADR-1:0];
         din_d = LB_UP_DIN_IN;
      end

      case (state_q)
         IDLE: begin
            if (rd_go) begin
               state_d = RD_WAIT;
               sel_d   = sel;
               cnt_d   = '0;
            end else if (rd_bad) begin
               vld_d  = 1'b1;
               dout_d = P_ERR_DAT;
            end
         end
         RD_WAIT: begin
            // Slave valid has priority over the terminal count.
            if (vld_sel) begin
               vld_d   = 1'b1;
               dout_d  = dat_sel;
               state_d = IDLE;
            end else if (rd_q == '0 && cnt_q == TERM) begin
               tmo_ev  = 1'b1;
               vld_d   = 1'b1;
               dout_d  = P_ERR_DAT;
               tport_d = 5'(sel_q);
               state_d = IDLE;
            end else if (rd_q == '0) begin
               // The strobe cycle itself is not charged to the slave, so the
               // error response lands P_TMO+1 cycles after the strobe.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      tmo_d = (tmo_q & ~STA_CLR_IN) | tmo_ev;
      dec_d = (dec_q & ~STA_CLR_IN) | dec_ev;
      ovr_d = (ovr_q & ~STA_CLR_IN) | ovr_ev;
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         adr_q   <= '0;
         din_q   <= '0;
         vld_q   <= 1'b0;
         dout_q  <= '0;
         tmo_q   <= 1'b0;
         dec_q   <= 1'b0;
         ovr_q   <= 1'b0;
         tport_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         adr_q   <= adr_d;
         din_q   <= din_d;
         vld_q   <= vld_d;
         dout_q  <= dout_d;
         tmo_q   <= tmo_d;
         dec_q   <= dec_d;
         ovr_q   <= ovr_d;
         tport_q <= tport_d;
      end
   end

   assign LB_UP_DOUT_OUT   = dout_q;
   assign LB_UP_VLD_OUT    = vld_q;
   assign LB_DWN_ADR_OUT   = adr_q;
   assign LB_DWN_DIN_OUT   = din_q;
   assign LB_DWN_WR_OUT    = wr_q;
   assign LB_DWN_RD_OUT    = rd_q;
   assign STA_TMO_OUT      = tmo_q;
   assign STA_TMO_PORT_OUT = tport_q;
   assign STA_DEC_OUT      = dec_q;
   assign STA_OVR_OUT      = ovr_q;
   assign STA_BUSY_OUT     = (state_q == RD_WAIT);

endmodule

// File: tb/tb_prt_lb_mux_tmo.sv
// Directed bench for prt_lb_mux_tmo with 9 ports and a 16-cycle timeout.
module tb_prt_lb_mux_tmo;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [21:0]  up_adr = '0;
   logic         up_wr = 1'b0, up_rd = 1'b0;
   logic [31:0]  up_din = '0;
   logic [31:0]  up_dout;
   logic         up_vld;
   logic [15:0]  dwn_adr;
   logic [31:0]  dwn_din;
   logic [8:0]   dwn_wr, dwn_rd;
   logic [287:0] dwn_dout = '0;
   logic [8:0]   dwn_vld = '0;
   logic         sta_clr = 1'b0;
   logic         sta_tmo, sta_dec, sta_ovr, sta_busy;
   logic [4:0]   sta_tmo_port;

   int n_cmp = 0;
   int n_err = 0;

   prt_lb_mux_tmo #(.P_PORTS(9), .P_UP_ADR(22), .P_DWN_ADR(16), .P_DAT(32),
                    .P_TMO(16), .P_ERR_DAT(32'hDEAD_BEEF)) dut (
      .CLK_IN(clk), .RST_IN(rst_n),
      .LB_UP_ADR_IN(up_adr), .LB_UP_WR_IN(up_wr), .LB_UP_RD_IN(up_rd),
      .LB_UP_DIN_IN(up_din), .LB_UP_DOUT_OUT(up_dout), .LB_UP_VLD_OUT(up_vld),
      .LB_DWN_ADR_OUT(dwn_adr), .LB_DWN_DIN_OUT(dwn_din),
      .LB_DWN_WR_OUT(dwn_wr), .LB_DWN_RD_OUT(dwn_rd),
      .LB_DWN_DOUT_IN(dwn_dout), .LB_DWN_VLD_IN(dwn_vld),
      .STA_CLR_IN(sta_clr), .STA_TMO_OUT(sta_tmo), .STA_TMO_PORT_OUT(sta_tmo_port),
      .STA_DEC_OUT(sta_dec), .STA_OVR_OUT(sta_ovr), .STA_BUSY_OUT(sta_busy));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wr, input logic rd, input int port,
                      input logic [15:0] a, input logic [31:0] d);
      up_wr  = wr;
      up_rd  = rd;
      up_adr = {2'b00, port[3:0], a};
      up_din = d;
   endtask

   task automatic idle_in();
      up_wr = 1'b0;
      up_rd = 1'b0;
   endtask

   task automatic clr_sta();
      sta_clr = 1'b1;
      tick();
      sta_clr = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({up_dout, up_vld, dwn_adr, dwn_din, dwn_wr, dwn_rd, sta_tmo, sta_tmo_port,
           sta_dec, sta_ovr, sta_busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outs: got dout=%h vld=%b wr=%b rd=%b busy=%b, want all 0",
                  up_dout, up_vld, dwn_wr, dwn_rd, sta_busy);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({up_vld, dwn_wr, dwn_rd, sta_busy} !== '0) begin
         n_err++;
         $display("FAIL reset_idle: got vld=%b wr=%b rd=%b busy=%b, want 0",
                  up_vld, dwn_wr, dwn_rd, sta_busy);
      end
   endtask

   task automatic test_write();
      req(1, 0, 3, 16'h0123, 32'hA5A5_A5A5);
      tick();
      idle_in();
      n_cmp++;
      if (dwn_wr !== 9'h008 || dwn_rd !== 9'h000) begin
         n_err++;
         $display("FAIL wr_strobe: got wr=%b rd=%b, want wr=000001000 rd=0", dwn_wr, dwn_rd);
      end
      n_cmp++;
      if (dwn_adr !== 16'h0123 || dwn_din !== 32'hA5A5_A5A5) begin
         n_err++;
         $display("FAIL wr_data: got adr=%h din=%h, want 0123 a5a5a5a5", dwn_adr, dwn_din);
      end
      tick();
      n_cmp++;
      if (dwn_wr !== 9'h000 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL wr_single: got wr=%b busy=%b, want 0 0", dwn_wr, sta_busy);
      end
   endtask

   task automatic test_read();
      logic bad;
      req(0, 1, 7, 16'h0040, 32'h0);
      tick();
      idle_in();
      n_cmp++;
      if (dwn_rd !== 9'h080 || dwn_adr !== 16'h0040 || sta_busy !== 1'b1) begin
         n_err++;
         $display("FAIL rd_strobe: got rd=%b adr=%h busy=%b, want 010000000 0040 1",
                  dwn_rd, dwn_adr, sta_busy);
      end
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (sta_busy !== 1'b1 || up_vld !== 1'b0) bad = 1'b1;
         tick();
      end
      n_cmp++;
      if (bad !== 1'b0) begin
         n_err++;
         $display("FAIL rd_wait: got busy drop or early vld=%b, want busy=1 vld=0", bad);
      end
      dwn_vld[7] = 1'b1;
      dwn_dout[7*32 +: 32] = 32'h1234_5678;
      tick();
      dwn_vld = '0;
      n_cmp++;
      if (up_vld !== 1'b1 || up_dout !== 32'h1234_5678 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rd_resp: got vld=%b dout=%h busy=%b, want 1 12345678 0",
                  up_vld, up_dout, sta_busy);
      end
      tick();
      n_cmp++;
      if (up_vld !== 1'b0 || up_dout !== 32'h1234_5678) begin
         n_err++;
         $display("FAIL rd_hold: got vld=%b dout=%h, want 0 12345678", up_vld, up_dout);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      req(0, 1, 5, 16'h0004, 32'h0);
      tick();
      idle_in();
      cyc = 0;
      while (up_vld !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      n_cmp++;
      if (cyc !== 17) begin
         n_err++;
         $display("FAIL tmo_latency: got %0d cycles after strobe, want 17", cyc);
      end
      n_cmp++;
      if (up_dout !== 32'hDEAD_BEEF || sta_tmo !== 1'b1 || sta_tmo_port !== 5'd5) begin
         n_err++;
         $display("FAIL tmo_resp: got dout=%h tmo=%b port=%0d, want deadbeef 1 5",
                  up_dout, sta_tmo, sta_tmo_port);
      end
      tick();
      tick();
      n_cmp++;
      if (sta_tmo !== 1'b1 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_sticky: got tmo=%b busy=%b, want 1 0", sta_tmo, sta_busy);
      end
      clr_sta();
      n_cmp++;
      if (sta_tmo !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_clear: got tmo=%b, want 0", sta_tmo);
      end
   endtask

   task automatic test_tmo_edge();
      logic early;
      // Valid on the terminal-count cycle must win over the timeout.
      req(0, 1, 2, 16'h0008, 32'h0);
      tick();
      idle_in();
      early = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (up_vld !== 1'b0) early = 1'b1;
         tick();
      end
      dwn_vld[2] = 1'b1;
      dwn_dout[2*32 +: 32] = 32'h0BAD_F00D;
      tick();
      dwn_vld = '0;
      n_cmp++;
      if (early !== 1'b0 || up_vld !== 1'b1 || up_dout !== 32'h0BAD_F00D || sta_tmo !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_edge: got early=%b vld=%b dout=%h tmo=%b, want 0 1 0badf00d 0",
                  early, up_vld, up_dout, sta_tmo);
      end
      // Same-cycle responder: valid alongside the downstream strobe.
      req(0, 1, 8, 16'h0001, 32'h0);
      tick();
      idle_in();
      dwn_vld[8] = 1'b1;
      dwn_dout[8*32 +: 32] = 32'h8888_0001;
      tick();
      dwn_vld = '0;
      n_cmp++;
      if (up_vld !== 1'b1 || up_dout !== 32'h8888_0001 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rd_same_cycle: got vld=%b dout=%h busy=%b, want 1 88880001 0",
                  up_vld, up_dout, sta_busy);
      end
   endtask

   task automatic test_decode();
      req(0, 1, 12, 16'h0010, 32'h0);
      tick();
      idle_in();
      n_cmp++;
      if (dwn_rd !== 9'h000 || up_vld !== 1'b1 || up_dout !== 32'hDEAD_BEEF ||
          sta_dec !== 1'b1 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL dec_read: got rd=%b vld=%b dout=%h dec=%b busy=%b, want 0 1 deadbeef 1 0",
                  dwn_rd, up_vld, up_dout, sta_dec, sta_busy);
      end
      clr_sta();
      req(1, 0, 12, 16'h0010, 32'h5555_AAAA);
      tick();
      idle_in();
      n_cmp++;
      if (dwn_wr !== 9'h000 || sta_dec !== 1'b1 || up_vld !== 1'b0) begin
         n_err++;
         $display("FAIL dec_write: got wr=%b dec=%b vld=%b, want 0 1 0", dwn_wr, sta_dec, up_vld);
      end
      clr_sta();
   endtask

   task automatic test_overrun();
      req(0, 1, 1, 16'h0020, 32'h0);
      tick();
      req(0, 1, 2, 16'h0030, 32'h0);
      dwn_vld[6] = 1'b1;
      dwn_dout[6*32 +: 32] = 32'h6666_6666;
      tick();
      req(1, 0, 4, 16'h0040, 32'h4444_4444);
      dwn_vld = '0;
      n_cmp++;
      if (dwn_rd !== 9'h000 || up_vld !== 1'b0 || sta_ovr !== 1'b1 || sta_busy !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_rd: got rd=%b vld=%b ovr=%b busy=%b, want 0 0 1 1",
                  dwn_rd, up_vld, sta_ovr, sta_busy);
      end
      tick();
      idle_in();
      n_cmp++;
      if (dwn_wr !== 9'h000 || sta_busy !== 1'b1 || up_vld !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_wr: got wr=%b busy=%b vld=%b, want 0 1 0", dwn_wr, sta_busy, up_vld);
      end
      dwn_vld[1] = 1'b1;
      dwn_dout[1*32 +: 32] = 32'hCAFE_F00D;
      tick();
      dwn_vld = '0;
      n_cmp++;
      if (up_vld !== 1'b1 || up_dout !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL ovr_complete: got vld=%b dout=%h, want 1 cafef00d", up_vld, up_dout);
      end
      clr_sta();
   endtask

   task automatic test_back_to_back();
      // Write and read together: write executes, read is dropped.
      req(1, 1, 0, 16'h0010, 32'h1111_2222);
      tick();
      req(1, 0, 1, 16'h0011, 32'h3333_4444);
      n_cmp++;
      if (dwn_wr !== 9'h001 || dwn_rd !== 9'h000 || sta_ovr !== 1'b1 || sta_busy !== 1'b0) begin
         n_err++;
         $display("FAIL wr_rd_same: got wr=%b rd=%b ovr=%b busy=%b, want 001 0 1 0",
                  dwn_wr, dwn_rd, sta_ovr, sta_busy);
      end
      tick();
      req(1, 0, 2, 16'h0012, 32'h5555_6666);
      sta_clr = 1'b1;
      n_cmp++;
      if (dwn_wr !== 9'h002 || dwn_adr !== 16'h0011 || dwn_din !== 32'h3333_4444) begin
         n_err++;
         $display("FAIL b2b_wr1: got wr=%b adr=%h din=%h, want 002 0011 33334444",
                  dwn_wr, dwn_adr, dwn_din);
      end
      tick();
      idle_in();
      sta_clr = 1'b0;
      n_cmp++;
      if (dwn_wr !== 9'h004 || dwn_adr !== 16'h0012 || sta_ovr !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_wr2: got wr=%b adr=%h ovr=%b, want 004 0012 0",
                  dwn_wr, dwn_adr, sta_ovr);
      end
      // Clear and a new drop event in the same cycle: the set wins.
      req(1, 1, 0, 16'h0000, 32'h0);
      sta_clr = 1'b1;
      tick();
      idle_in();
      sta_clr = 1'b0;
      n_cmp++;
      if (sta_ovr !== 1'b1) begin
         n_err++;
         $display("FAIL clr_vs_set: got ovr=%b, want 1", sta_ovr);
      end
      clr_sta();
   endtask

   task automatic test_reset_mid();
      logic seen;
      req(0, 1, 3, 16'h0050, 32'h0);
      tick();
      idle_in();
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({up_dout, up_vld, dwn_wr, dwn_rd, sta_busy, sta_ovr, sta_dec, sta_tmo} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_outs: got dout=%h vld=%b busy=%b, want all 0",
                  up_dout, up_vld, sta_busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      dwn_vld[3] = 1'b1;
      dwn_dout[3*32 +: 32] = 32'h3333_3333;
      tick();
      dwn_vld = '0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (up_vld !== 1'b0 || sta_busy !== 1'b0) seen = 1'b1;
         tick();
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_novld: got stale vld/busy=%b, want 0", seen);
      end
      req(0, 1, 3, 16'h0051, 32'h0);
      tick();
      idle_in();
      dwn_vld[3] = 1'b1;
      dwn_dout[3*32 +: 32] = 32'h0300_0051;
      tick();
      dwn_vld = '0;
      n_cmp++;
      if (up_vld !== 1'b1 || up_dout !== 32'h0300_0051) begin
         n_err++;
         $display("FAIL rst_mid_next: got vld=%b dout=%h, want 1 03000051", up_vld, up_dout);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_tmo_edge();
      test_decode();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
